// File: rtl/mips_if_pkg.sv
// Shared IF-stage constants: loader FSM states, instruction width,
// byte size and the end-of-program marker.
package mips_if_pkg;

  localparam int BYTE_SIZE       = 8;
  localparam int WORD_WIDTH_BITS = 4 * BYTE_SIZE;

  localparam logic [WORD_WIDTH_BITS-1:0] HALT_WORD = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_RECV,
    ST_WRITE,
    ST_DONE
  } ld_state_e;

endpackage

// File: rtl/instruction_loader.sv
// Byte-stream to instruction-memory loader.
// Ports: i_clk/i_reset_n, i_start, i_byte_valid/i_byte/o_byte_ready byte
// handshake, i_mem_full; o_clear, o_inst_write, o_instruction to memory;
// o_busy, o_done, o_error, o_word_count status.
module instruction_loader #(
  parameter int WORD_WIDTH_BITS = mips_if_pkg::WORD_WIDTH_BITS,
  parameter int MEM_SIZE_WORDS  = 10,
  parameter logic [WORD_WIDTH_BITS-1:0] HALT_WORD = mips_if_pkg::HALT_WORD,
  parameter int COUNT_WIDTH     = $clog2(MEM_SIZE_WORDS + 1)
) (
  input  logic                       i_clk,
  input  logic                       i_reset_n,
  input  logic                       i_start,
  input  logic                       i_byte_valid,
  input  logic [7:0]                 i_byte,
  output logic                       o_byte_ready,
  input  logic                       i_mem_full,
  output logic                       o_clear,
  output logic                       o_inst_write,
  output logic [WORD_WIDTH_BITS-1:0] o_instruction,
  output logic                       o_busy,
  output logic                       o_done,
  output logic                       o_error,
  output logic [COUNT_WIDTH-1:0]     o_word_count
);

  import mips_if_pkg::*;

  localparam logic [COUNT_WIDTH-1:0] CNT_MAX =
    COUNT_WIDTH'(MEM_SIZE_WORDS);
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE =
    COUNT_WIDTH'(1);

  ld_state_e                  state_q, state_d;
  logic [1:0]                 idx_q, idx_d;
  logic [WORD_WIDTH_BITS-1:0] shreg_q, shreg_d;
  logic [WORD_WIDTH_BITS-1:0] inst_q, inst_d;
  logic [COUNT_WIDTH-1:0]     cnt_q, cnt_d;
  logic                       err_q, err_d;
  logic                       ready_q, ready_d;
  logic                       clear_q, clear_d;
  logic                       wr_q, wr_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    inst_d  = inst_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (i_start) begin
          state_d = ST_CLEAR;
          idx_d   = '0;
          shreg_d = '0;
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end
      ST_CLEAR: state_d = ST_RECV;
      ST_RECV: begin
        if (i_byte_valid && ready_q) begin
          shreg_d = {shreg_q[WORD_WIDTH_BITS-BYTE_SIZE-1:0], i_byte};
          idx_d   = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            if (i_mem_full) begin
              state_d = ST_DONE;
              err_d   = 1'b1;
            end else begin
              state_d = ST_WRITE;
              inst_d  = shreg_d;
            end
          end
        end
      end
      ST_WRITE: begin
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_ONE;
        if (shreg_q == HALT_WORD || cnt_q + CNT_ONE == CNT_MAX)
          state_d = ST_DONE;
        else
          state_d = ST_RECV;
      end
      default: state_d = ST_IDLE;
    endcase
    // Outputs are registered off the next state so they line up
    // exactly with the state they describe.
    ready_d = (state_d == ST_RECV);
    clear_d = (state_d == ST_CLEAR);
    wr_d    = (state_d == ST_WRITE);
    done_d  = (state_d == ST_DONE);
    busy_d  = (state_d == ST_CLEAR) || (state_d == ST_RECV) ||
              (state_d == ST_WRITE);
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      shreg_q <= '0;
      inst_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      ready_q <= 1'b0;
      clear_q <= 1'b0;
      wr_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      inst_q  <= inst_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      ready_q <= ready_d;
      clear_q <= clear_d;
      wr_q    <= wr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign o_byte_ready  = ready_q;
  assign o_clear       = clear_q;
  assign o_inst_write  = wr_q;
  assign o_instruction = inst_q;
  assign o_busy        = busy_q;
  assign o_done        = done_q;
  assign o_error       = err_q;
  assign o_word_count  = cnt_q;

endmodule
